// File: rtl/mi_operand_feeder.sv
// rtl/mi_operand_feeder.sv - operand buffer and sequencer in front of a modular-inverse stage
//
// Purpose:
//   Collects one operand pair (a, p) from a host stream, N words of K bits
//   each, least-significant word first. It validates the length, the parity of
//   p and that a is non-zero. It then pulses mi_start and streams the buffered
//   words to the inverse stage, and waits for that stage to complete.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_valid/s_ready       host beat handshake
//   s_a_word, s_p_word    operand words (same index per beat)
//   s_last                final beat of an operand pair
//   mi_start              one-cycle start pulse to the inverse stage
//   mi_valid_in           word valid to the inverse stage
//   mi_a, mi_p            buffered words, zero when mi_valid_in is low
//   mi_valid_out          completion pulse from the inverse stage
//   busy                  high whenever not IDLE
//   err, err_code         error pulse; code 01 length, 10 p even, 11 a zero

module mi_operand_feeder #(
  parameter int K = 128,
  parameter int N = 32,
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [K-1:0] s_a_word,
  input  logic [K-1:0] s_p_word,
  input  logic         s_last,
  output logic         mi_start,
  output logic         mi_valid_in,
  output logic [K-1:0] mi_a,
  output logic [K-1:0] mi_p,
  input  logic         mi_valid_out,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_CHECK, S_START, S_STREAM, S_WAIT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_idx;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_a_nz;
  logic              r_p_odd;
  logic              r_err;
  logic [1:0]        r_err_code;

  // One write port (host side), one read port (stream side); {p, a} per entry.
  logic [2*K-1:0]    r_mem [N];

  logic              w_accept;
  logic              w_wr_en;
  logic              w_wr_at_end;
  logic              w_rd_at_end;
  logic              w_stream;
  logic [2*K-1:0]    w_rd_word;

  assign s_ready     = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_accept    = s_valid && s_ready;
  assign w_wr_en     = w_accept && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_wr_at_end = (r_wr_idx == ADDR_W'(N - 1));
  assign w_rd_at_end = (r_rd_idx == ADDR_W'(N - 1));
  assign w_stream    = (r_state == S_STREAM);
  assign w_rd_word   = r_mem[r_rd_idx];

  // Outputs decode only the state register, so they change on clock edges only.
  assign mi_start    = (r_state == S_START);
  assign mi_valid_in = w_stream;
  assign mi_a        = w_stream ? w_rd_word[K-1:0]   : '0;
  assign mi_p        = w_stream ? w_rd_word[2*K-1:K] : '0;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign err_code    = r_err_code;

  // Buffer contents survive reset; nothing reads them before a fresh load.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_idx] <= {s_p_word, s_a_word};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_a_nz     <= 1'b0;
      r_p_odd    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_idx <= '0;
          if (w_accept) begin
            r_a_nz  <= |s_a_word;
            r_p_odd <= s_p_word[0];
            if (s_last) begin
              // A one-beat pair is always short because N >= 2.
              r_err      <= 1'b1;
              r_err_code <= 2'b01;
            end else begin
              r_wr_idx <= ADDR_W'(1);
              r_state  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_a_nz <= r_a_nz | (|s_a_word);
            if (s_last) begin
              r_wr_idx <= '0;
              if (w_wr_at_end) begin
                r_state <= S_CHECK;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= 2'b01;
                r_state    <= S_IDLE;
              end
            end else if (w_wr_at_end) begin
              // Too long: flag now, then swallow the rest of the pair.
              r_wr_idx   <= '0;
              r_err      <= 1'b1;
              r_err_code <= 2'b01;
              r_state    <= S_DRAIN;
            end else begin
              r_wr_idx <= r_wr_idx + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          r_wr_idx <= '0;
          if (w_accept && s_last) begin
            r_state <= S_IDLE;
          end
        end
        S_CHECK: begin
          r_wr_idx <= '0;
          // Even modulus outranks a zero operand.
          if (!r_p_odd) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
            r_state    <= S_IDLE;
          end else if (!r_a_nz) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
            r_state    <= S_IDLE;
          end else begin
            r_state <= S_START;
          end
        end
        S_START: begin
          r_rd_idx <= '0;
          r_state  <= S_STREAM;
        end
        S_STREAM: begin
          if (w_rd_at_end) begin
            r_rd_idx <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_rd_idx <= r_rd_idx + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          if (mi_valid_out) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mi_operand_feeder.md
MI_OPERAND_FEEDER -- requirements
Module: mi_operand_feeder

Interface
REQ-001 Parameter K, 128, word width in bits.
REQ-002 Parameter N, 32, words per operand (N >= 2); ADDR_W = clog2(N).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  host beat valid.
REQ-006 s_ready  output  1  feeder accepts beat.
REQ-007 s_a_word  input  K  word of operand a, least-significant word first.
REQ-008 s_p_word  input  K  word of modulus p, same index as s_a_word.
REQ-009 s_last  input  1  marks final beat of an operand pair.
REQ-010 mi_start  output  1  one-cycle start pulse to the inverse stage.
REQ-011 mi_valid_in  output  1  word-valid to the inverse stage.
REQ-012 mi_a  output  K  a word to the inverse stage.
REQ-013 mi_p  output  K  p word to the inverse stage.
REQ-014 mi_valid_out  input  1  completion pulse from the inverse stage.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  one-cycle error pulse.
REQ-017 err_code  output  2  01 length, 10 p even, 11 a zero; held until next err.

Function
REQ-018 States SHALL be IDLE, LOAD, DRAIN, CHECK, START, STREAM, WAIT.
REQ-019 s_ready SHALL be 1 in IDLE, LOAD and DRAIN, else 0; a beat is accepted when s_valid & s_ready.
REQ-020 Accepted beat i (0..N-1) SHALL be written to internal buffer index i; the word counter clears on entering IDLE.
REQ-021 IDLE: first accepted beat SHALL be stored as index 0 and move to LOAD (to IDLE with err_code 01 if s_last=1 and N>1).
REQ-022 LOAD: a beat with s_last=1 at index N-1 SHALL move to CHECK; s_last=1 at index < N-1 SHALL pulse err, err_code 01, return to IDLE.
REQ-023 LOAD: a beat at index N-1 with s_last=0 SHALL pulse err, err_code 01, move to DRAIN.
REQ-024 DRAIN: beats SHALL be discarded until one with s_last=1 is accepted, then IDLE.
REQ-025 A running OR of all a words and bit 0 of p word 0 SHALL be tracked during LOAD.
REQ-026 CHECK (1 cycle): p[0]=0 SHALL give err, err_code 10, IDLE; else a==0 SHALL give err, err_code 11, IDLE; else START. p even takes priority.
REQ-027 START (1 cycle): mi_start=1, then STREAM.
REQ-028 STREAM: mi_valid_in=1 for exactly N consecutive cycles beginning the cycle after mi_start; cycle j carries buffer word j on mi_a/mi_p; then WAIT.
REQ-029 mi_a/mi_p SHALL be 0 whenever mi_valid_in=0.
REQ-030 WAIT: mi_valid_out=1 SHALL return to IDLE; mi_valid_out in any other state SHALL be ignored.
REQ-031 Latency: mi_start SHALL assert 2 cycles after the accepted s_last beat (CHECK, then START).
REQ-032 s_valid while s_ready=0 SHALL be ignored, no state change.
REQ-033 Buffer storage SHALL be N entries of 2K bits, one write port, one read port.

Reset
REQ-034 rst=1 SHALL force IDLE, counters 0, s_ready=1, mi_start=0, mi_valid_in=0, mi_a=0, mi_p=0, busy=0, err=0, err_code=00.
REQ-035 rst during STREAM or WAIT SHALL abort immediately; buffer contents need not be cleared.

Verification (K=128, N=4)
REQ-036 Beats a={5,0,0,0}, p={0x..61(odd),1,2,3}, s_last on 4th -> mi_start 2 cycles later, then mi_valid_in 4 cycles with mi_a 5,0,0,0 and mi_p in order; busy until mi_valid_out.
REQ-037 s_last on 3rd beat -> err pulse, err_code 01, no mi_start, s_ready stays 1, next pair processed normally.
REQ-038 4 beats with no s_last, then 2 more with s_last on 6th -> err_code 01 on 4th beat, beats 5-6 discarded, IDLE after 6th.
REQ-039 p word0=0x10 (even), a=0 -> err_code 10 only (priority), no mi_start.
REQ-040 a all zero, p odd -> err_code 11, no mi_start.
REQ-041 rst asserted on 2nd STREAM cycle -> next cycle mi_valid_in=0, busy=0; mi_valid_out during IDLE ignored.
